// File: rtl/gba_io_mem_pkg.sv
// Shared types and helpers for the cart/USB memory request path.
// Width codes, responder FSM states, and byte-lane / beat data helpers.
package gba_io_mem_pkg;

   localparam logic [1:0] DATA_WIDTH_0  = 2'b00;
   localparam logic [1:0] DATA_WIDTH_8  = 2'b01;
   localparam logic [1:0] DATA_WIDTH_16 = 2'b10;
   localparam logic [1:0] DATA_WIDTH_32 = 2'b11;

   typedef enum logic [1:0] {
      MW_NONE = DATA_WIDTH_0,
      MW_8    = DATA_WIDTH_8,
      MW_16   = DATA_WIDTH_16,
      MW_32   = DATA_WIDTH_32
   } mem_width_t;

   typedef enum logic [2:0] {
      RS_IDLE   = 3'd0,
      RS_SETUP  = 3'd1,
      RS_STROBE = 3'd2,
      RS_HOLD   = 3'd3,
      RS_DONE   = 3'd4
   } resp_state_t;

   // Returns {ub_n, lb_n}; byte accesses pick the lane from the address LSB.
   function automatic logic [1:0] lane_enables_n(input mem_width_t w, input logic a0);
      case (w)
         MW_8:    return a0 ? 2'b01 : 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [15:0] beat_wdata(input mem_width_t w, input logic [31:0] d,
                                              input logic upper);
      case (w)
         MW_8:    return {d[7:0], d[7:0]};
         MW_32:   return upper ? d[31:16] : d[15:0];
         default: return d[15:0];
      endcase
   endfunction

   function automatic logic [31:0] merge_rdata(input mem_width_t w, input logic a0,
                                               input logic upper, input logic [31:0] acc,
                                               input logic [15:0] dq);
      logic [31:0] r;
      r = acc;
      case (w)
         MW_8:    r[7:0] = a0 ? dq[15:8] : dq[7:0];
         MW_16:   r[15:0] = dq;
         MW_32:   if (upper) r[31:16] = dq; else r[15:0] = dq;
         default: r = acc;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_responder.sv
// Responder side of the memory request interface: runs each accepted request as one or
// two 16-bit beats (SETUP / STROBE / HOLD) on an asynchronous SRAM/PSRAM bus.
module mem_responder
   import gba_io_mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int HADDR_W     = 25
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mem_rd,
   input  logic               mem_wr,
   input  logic [HADDR_W:0]   mem_addr,
   input  logic [1:0]         mem_data_width,
   input  logic [31:0]        mem_wr_data,
   output logic               mem_rd_ready,
   output logic               mem_wr_ready,
   output logic               mem_rd_valid,
   output logic [31:0]        mem_rd_data,
   output logic [HADDR_W-1:0] sram_addr,
   input  logic [15:0]        sram_dq_i,
   output logic [15:0]        sram_dq_o,
   output logic               sram_dq_oe,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic               sram_ub_n,
   output logic               sram_lb_n
);

   localparam int              CNT_W    = $clog2(WAIT_CYCLES + 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

   resp_state_t      state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             is_rd_r;
   mem_width_t       width_r;
   logic             lane_r;
   logic             upper_r;
   logic [31:0]      wdata_r;
   logic [31:0]      acc_r;

   logic             take_rd_s;
   logic             accept_s;
   mem_width_t       req_width_s;

   // Read has priority over a simultaneous write; nothing is taken outside IDLE.
   assign take_rd_s   = mem_rd & mem_rd_ready;
   assign accept_s    = (state_r == RS_IDLE) & (take_rd_s | (mem_wr & mem_wr_ready));
   assign req_width_s = mem_width_t'(mem_data_width);

   // Request FSM with all bus and handshake outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= RS_IDLE;
         cnt_r        <= '0;
         is_rd_r      <= 1'b0;
         width_r      <= MW_NONE;
         lane_r       <= 1'b0;
         upper_r      <= 1'b0;
         wdata_r      <= 32'h0000_0000;
         acc_r        <= 32'h0000_0000;
         mem_rd_ready <= 1'b0;
         mem_wr_ready <= 1'b0;
         mem_rd_valid <= 1'b0;
         mem_rd_data  <= 32'h0000_0000;
         sram_addr    <= '0;
         sram_dq_o    <= 16'h0000;
         sram_dq_oe   <= 1'b0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_ub_n    <= 1'b1;
         sram_lb_n    <= 1'b1;
      end else begin
         mem_rd_valid <= 1'b0;
         case (state_r)
            RS_IDLE: begin
               if (accept_s) begin
                  mem_rd_ready <= 1'b0;
                  mem_wr_ready <= 1'b0;
                  is_rd_r      <= take_rd_s;
                  width_r      <= req_width_s;
                  lane_r       <= mem_addr[0];
                  upper_r      <= 1'b0;
                  wdata_r      <= mem_wr_data;
                  acc_r        <= 32'h0000_0000;
                  if (req_width_s == MW_NONE) begin
                     state_r <= RS_DONE;
                  end else begin
                     state_r                <= RS_SETUP;
                     sram_addr              <= mem_addr[HADDR_W:1];
                     sram_ce_n              <= 1'b0;
                     {sram_ub_n, sram_lb_n} <= lane_enables_n(req_width_s, mem_addr[0]);
                     sram_dq_oe             <= ~take_rd_s;
                     sram_dq_o              <= take_rd_s ? 16'h0000
                                               : beat_wdata(req_width_s, mem_wr_data, 1'b0);
                  end
               end else begin
                  mem_rd_ready <= 1'b1;
                  mem_wr_ready <= 1'b1;
               end
            end
            RS_SETUP: begin
               state_r   <= RS_STROBE;
               cnt_r     <= '0;
               sram_oe_n <= ~is_rd_r;
               sram_we_n <= is_rd_r;
            end
            RS_STROBE: begin
               if (cnt_r == CNT_LAST) begin
                  state_r   <= RS_HOLD;
                  sram_oe_n <= 1'b1;
                  sram_we_n <= 1'b1;
                  if (is_rd_r) begin
                     acc_r <= merge_rdata(width_r, lane_r, upper_r, acc_r, sram_dq_i);
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            RS_HOLD: begin
               // Second beat of a 32-bit access keeps the chip selected; address wraps.
               if ((width_r == MW_32) && !upper_r) begin
                  state_r   <= RS_SETUP;
                  upper_r   <= 1'b1;
                  sram_addr <= sram_addr + HADDR_W'(1);
                  sram_dq_o <= is_rd_r ? 16'h0000 : beat_wdata(width_r, wdata_r, 1'b1);
               end else begin
                  state_r    <= RS_DONE;
                  sram_ce_n  <= 1'b1;
                  sram_ub_n  <= 1'b1;
                  sram_lb_n  <= 1'b1;
                  sram_dq_oe <= 1'b0;
               end
            end
            RS_DONE: begin
               state_r <= RS_IDLE;
               if (is_rd_r) begin
                  mem_rd_valid <= 1'b1;
                  mem_rd_data  <= acc_r;
               end
            end
            default: begin
               state_r    <= RS_IDLE;
               sram_ce_n  <= 1'b1;
               sram_oe_n  <= 1'b1;
               sram_we_n  <= 1'b1;
               sram_ub_n  <= 1'b1;
               sram_lb_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYCLES 2, 0, 5) each on a behavioural SRAM,
// with a byte-level reference memory and beat / read-data scoreboards.
module tb_mem_responder;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        rd [3];
   logic        wr [3];
   logic [25:0] addr [3];
   logic [1:0]  dw [3];
   logic [31:0] wdat [3];
   logic        rd_rdy [3];
   logic        wr_rdy [3];
   logic        vld [3];
   logic [31:0] rdat [3];
   logic [24:0] saddr [3];
   logic [15:0] dqi [3];
   logic [15:0] dqo [3];
   logic        dqoe [3];
   logic        ce_n [3];
   logic        oe_n [3];
   logic        we_n [3];
   logic        ub_n [3];
   logic        lb_n [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_responder #(
         .WAIT_CYCLES (g == 0 ? 2 : (g == 1 ? 0 : 5)),
         .HADDR_W     (25)
      ) u_dut (
         .clk            (clk),
         .rst_n          (rst_n),
         .mem_rd         (rd[g]),
         .mem_wr         (wr[g]),
         .mem_addr       (addr[g]),
         .mem_data_width (dw[g]),
         .mem_wr_data    (wdat[g]),
         .mem_rd_ready   (rd_rdy[g]),
         .mem_wr_ready   (wr_rdy[g]),
         .mem_rd_valid   (vld[g]),
         .mem_rd_data    (rdat[g]),
         .sram_addr      (saddr[g]),
         .sram_dq_i      (dqi[g]),
         .sram_dq_o      (dqo[g]),
         .sram_dq_oe     (dqoe[g]),
         .sram_ce_n      (ce_n[g]),
         .sram_oe_n      (oe_n[g]),
         .sram_we_n      (we_n[g]),
         .sram_ub_n      (ub_n[g]),
         .sram_lb_n      (lb_n[g])
      );
   end

   typedef struct {
      int          k;
      bit          is_wr;
      logic [24:0] haddr;
      logic [1:0]  lanes_n;
      logic [15:0] wdata;
   } beat_t;

   typedef struct {
      int          k;
      logic [31:0] data;
   } rdx_t;

   beat_t      beat_q [$];
   rdx_t       rd_q [$];
   bit [15:0]  sram_m [bit [26:0]];
   bit [7:0]   ref_b [bit [27:0]];
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         vld_cyc [3];
   int         oe_cnt [3];
   int         we_cnt [3];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int wc_of(input int k);
      case (k)
         0:       return 2;
         1:       return 0;
         default: return 5;
      endcase
   endfunction

   function automatic bit [15:0] sram_rd(input int k, input logic [24:0] h);
      bit [26:0] key;
      key = {k[1:0], h};
      return sram_m.exists(key) ? sram_m[key] : 16'h0000;
   endfunction

   function automatic bit [7:0] rb(input int k, input logic [25:0] ba);
      bit [27:0] key;
      key = {k[1:0], ba};
      return ref_b.exists(key) ? ref_b[key] : 8'h00;
   endfunction

   function automatic void wb(input int k, input logic [25:0] ba, input logic [7:0] v);
      ref_b[{k[1:0], ba}] = v;
   endfunction

   // End of an OE_n/WE_n strobe: check width, match the expected beat, commit writes.
   task automatic strobe_end(input int k, input bit is_wr, input int cnt);
      beat_t     b;
      bit [15:0] cur;
      bit [26:0] key;
      n_vec++;
      if (cnt != wc_of(k) + 1) begin
         n_err++;
         $display("FAIL strobe_width inst %0d wr=%0d: got %0d cycles, required %0d", k, is_wr, cnt, wc_of(k) + 1);
      end
      n_vec++;
      if (beat_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_beat inst %0d wr=%0d haddr=%h", k, is_wr, saddr[k]);
      end else begin
         b = beat_q.pop_front();
         if (b.k != k || b.is_wr != is_wr || b.haddr !== saddr[k] || b.lanes_n !== {ub_n[k], lb_n[k]}
             || (is_wr && b.wdata !== dqo[k]) || ce_n[k] !== 1'b0) begin
            n_err++;
            $display("FAIL beat: got inst %0d wr=%0d haddr=%h lanes_n=%b dq=%h ce_n=%b, required inst %0d wr=%0d haddr=%h lanes_n=%b dq=%h ce_n=0",
                     k, is_wr, saddr[k], {ub_n[k], lb_n[k]}, dqo[k], ce_n[k],
                     b.k, b.is_wr, b.haddr, b.lanes_n, b.wdata);
         end
      end
      if (is_wr) begin
         key = {k[1:0], saddr[k]};
         cur = sram_rd(k, saddr[k]);
         if (!lb_n[k]) cur[7:0] = dqo[k][7:0];
         if (!ub_n[k]) cur[15:8] = dqo[k][15:8];
         sram_m[key] = cur;
      end
   endtask

   // SRAM model and read-data monitor, both sampled on the falling edge.
   always @(negedge clk) begin
      rdx_t r;
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            oe_cnt[k] = 0;
            we_cnt[k] = 0;
            dqi[k]    = 16'hDEAD;
         end else begin
            if (!oe_n[k]) begin
               n_vec++;
               if (dqoe[k] !== 1'b0) begin
                  n_err++;
                  $display("FAIL dq_oe_overlap inst %0d: got dq_oe=%b with oe_n=0, required 0", k, dqoe[k]);
               end
               oe_cnt[k]++;
               dqi[k] = sram_rd(k, saddr[k]);
            end else begin
               if (oe_cnt[k] != 0) strobe_end(k, 1'b0, oe_cnt[k]);
               oe_cnt[k] = 0;
               dqi[k]    = 16'hDEAD;
            end
            if (!we_n[k]) begin
               we_cnt[k]++;
            end else begin
               if (we_cnt[k] != 0) strobe_end(k, 1'b1, we_cnt[k]);
               we_cnt[k] = 0;
            end
            if (vld[k] === 1'b1) begin
               n_vec++;
               vld_cyc[k] = cyc;
               if (rd_q.size() == 0) begin
                  n_err++;
                  $display("FAIL spurious_valid inst %0d data=%h", k, rdat[k]);
               end else begin
                  r = rd_q.pop_front();
                  if (r.k != k || rdat[k] !== r.data) begin
                     n_err++;
                     $display("FAIL rd_data: got inst %0d data %h, required inst %0d data %h", k, rdat[k], r.k, r.data);
                  end
               end
            end
         end
      end
   end

   // One request: push expectations, wait for ready, pulse, then check latencies.
   task automatic do_req(input int k, input bit rd_i, input bit wr_i, input logic [25:0] a,
                         input logic [1:0] w, input logic [31:0] wd, input bit poke);
      int          nb;
      int          exp_rdy;
      int          t;
      int          i;
      logic [24:0] h0;
      logic [24:0] h1;
      beat_t       bt;
      rdx_t        rx;
      nb  = (w == 2'b11) ? 2 : ((w == 2'b00) ? 0 : 1);
      h0  = a[25:1];
      h1  = h0 + 25'd1;
      exp_rdy = (nb == 0) ? 2 : nb * (wc_of(k) + 3) + 2;
      for (int b = 0; b < nb; b++) begin
         bt.k       = k;
         bt.is_wr   = !rd_i;
         bt.haddr   = (b == 1) ? h1 : h0;
         bt.lanes_n = (w == 2'b01) ? (a[0] ? 2'b01 : 2'b10) : 2'b00;
         bt.wdata   = (w == 2'b01) ? {wd[7:0], wd[7:0]} : ((b == 1) ? wd[31:16] : wd[15:0]);
         beat_q.push_back(bt);
      end
      if (rd_i) begin
         rx.k = k;
         case (w)
            2'b01:   rx.data = {24'h0, rb(k, a)};
            2'b10:   rx.data = {16'h0, rb(k, {h0, 1'b1}), rb(k, {h0, 1'b0})};
            2'b11:   rx.data = {rb(k, {h1, 1'b1}), rb(k, {h1, 1'b0}), rb(k, {h0, 1'b1}), rb(k, {h0, 1'b0})};
            default: rx.data = 32'h0;
         endcase
         rd_q.push_back(rx);
      end else if (wr_i) begin
         if (w == 2'b01) wb(k, a, wd[7:0]);
         if (w[1]) begin
            wb(k, {h0, 1'b0}, wd[7:0]);
            wb(k, {h0, 1'b1}, wd[15:8]);
         end
         if (w == 2'b11) begin
            wb(k, {h1, 1'b0}, wd[23:16]);
            wb(k, {h1, 1'b1}, wd[31:24]);
         end
      end
      for (i = 0; i < 64 && !(rd_rdy[k] === 1'b1 && wr_rdy[k] === 1'b1); i++) @(negedge clk);
      n_vec++;
      if (i == 64) begin
         n_err++;
         $display("FAIL ready_timeout inst %0d before request", k);
         return;
      end
      vld_cyc[k] = -1;
      rd[k] = rd_i; wr[k] = wr_i; addr[k] = a; dw[k] = w; wdat[k] = wd;
      @(posedge clk);
      #1;
      t = cyc;
      rd[k] = 1'b0; wr[k] = 1'b0;
      n_vec++;
      if (rd_rdy[k] !== 1'b0 || wr_rdy[k] !== 1'b0) begin
         n_err++;
         $display("FAIL ready_drop inst %0d: got %b%b, required 00", k, rd_rdy[k], wr_rdy[k]);
      end
      if (w == 2'b00) begin
         n_vec++;
         if (ce_n[k] !== 1'b1) begin
            n_err++;
            $display("FAIL no_bus_cycle inst %0d: got ce_n=%b, required 1", k, ce_n[k]);
         end
      end
      if (poke) begin
         rd[k] = 1'b1; wr[k] = 1'b1; addr[k] = 26'h0000_3C4; dw[k] = 2'b10; wdat[k] = 32'h0000_9999;
         @(posedge clk);
         #1;
         rd[k] = 1'b0; wr[k] = 1'b0;
      end
      for (i = 0; i < 64; i++) begin
         @(negedge clk);
         if (rd_rdy[k] === 1'b1) break;
      end
      n_vec++;
      if (cyc - t != exp_rdy) begin
         n_err++;
         $display("FAIL ready_latency inst %0d: got T+%0d, required T+%0d", k, cyc - t, exp_rdy);
      end
      if (rd_i) begin
         n_vec++;
         if (vld_cyc[k] - t != exp_rdy - 1) begin
            n_err++;
            $display("FAIL valid_latency inst %0d: got T+%0d, required T+%0d", k, vld_cyc[k] - t, exp_rdy - 1);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if ({rd_rdy[k], wr_rdy[k], vld[k], dqoe[k], ce_n[k], oe_n[k], we_n[k], ub_n[k], lb_n[k]} !== 9'b0000_11111
             || rdat[k] !== 32'h0 || saddr[k] !== 25'h0 || dqo[k] !== 16'h0) begin
            n_err++;
            $display("FAIL reset_state inst %0d: got rdy%b%b vld%b oe%b strobes%b%b%b%b%b data %h addr %h dq %h, required all 0 with strobes 1",
                     k, rd_rdy[k], wr_rdy[k], vld[k], dqoe[k], ce_n[k], oe_n[k], we_n[k], ub_n[k], lb_n[k], rdat[k], saddr[k], dqo[k]);
         end
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (rd_rdy[k] !== 1'b1 || wr_rdy[k] !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset inst %0d: got %b%b, required 11", k, rd_rdy[k], wr_rdy[k]);
         end
      end
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      rd[0] = 1'b1; addr[0] = 26'h0000_400; dw[0] = 2'b11;
      @(posedge clk);
      #1;
      rd[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (oe_n[0] !== 1'b0) begin
         n_err++;
         $display("FAIL strobe_started: got oe_n=%b, required 0", oe_n[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({ce_n[0], oe_n[0], we_n[0], vld[0], rd_rdy[0], dqoe[0]} !== 6'b111_000) begin
         n_err++;
         $display("FAIL abort_on_reset: got ce/oe/we %b%b%b vld %b rdy %b oe %b, required 111 0 0 0",
                  ce_n[0], oe_n[0], we_n[0], vld[0], rd_rdy[0], dqoe[0]);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if (rd_rdy[0] !== 1'b1) begin
         n_err++;
         $display("FAIL ready_after_abort: got %b, required 1", rd_rdy[0]);
      end
   endtask

   task automatic test_16b();
      do_req(0, 1'b0, 1'b1, 26'h000_0100, 2'b10, 32'h0000_BEEF, 1'b0);
      do_req(0, 1'b1, 1'b0, 26'h000_0101, 2'b10, 32'h0, 1'b0);
   endtask

   task automatic test_8b();
      do_req(0, 1'b0, 1'b1, 26'h000_0201, 2'b01, 32'h0000_00AA, 1'b0);
      do_req(0, 1'b1, 1'b0, 26'h000_0200, 2'b01, 32'h0, 1'b0);
      do_req(0, 1'b1, 1'b0, 26'h000_0201, 2'b01, 32'h0, 1'b0);
   endtask

   task automatic test_32b_wrap();
      do_req(0, 1'b0, 1'b1, 26'h3FF_FFFE, 2'b11, 32'h1234_5678, 1'b0);
      do_req(0, 1'b1, 1'b0, 26'h3FF_FFFE, 2'b11, 32'h0, 1'b0);
   endtask

   task automatic test_collision();
      do_req(0, 1'b1, 1'b1, 26'h000_0040, 2'b00, 32'h5555_5555, 1'b0);
      do_req(0, 1'b1, 1'b1, 26'h000_0100, 2'b10, 32'h0000_1111, 1'b0);
      do_req(0, 1'b0, 1'b1, 26'h000_0044, 2'b00, 32'h7777_7777, 1'b1);
      do_req(0, 1'b1, 1'b0, 26'h000_0100, 2'b10, 32'h0, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k++) begin
         do_req(k, 1'b0, 1'b1, 26'h000_0010, 2'b11, 32'hCAFE_F00D, 1'b1);
         do_req(k, 1'b0, 1'b1, 26'h000_0015, 2'b01, 32'h0000_005A, 1'b0);
         do_req(k, 1'b0, 1'b1, 26'h000_0022, 2'b10, 32'h0000_A5C3, 1'b1);
         do_req(k, 1'b1, 1'b0, 26'h000_0010, 2'b11, 32'h0, 1'b0);
         do_req(k, 1'b1, 1'b0, 26'h000_0015, 2'b01, 32'h0, 1'b0);
         do_req(k, 1'b1, 1'b0, 26'h000_0014, 2'b10, 32'h0, 1'b0);
         do_req(k, 1'b1, 1'b0, 26'h000_0023, 2'b10, 32'h0, 1'b1);
         do_req(k, 1'b1, 1'b1, 26'h000_0030, 2'b00, 32'h0, 1'b0);
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 26'h0; dw[k] = 2'b00; wdat[k] = 32'h0;
         vld_cyc[k] = -1; oe_cnt[k] = 0; we_cnt[k] = 0;
      end
      #2;
      test_reset();
      test_reset_mid_read();
      test_16b();
      test_8b();
      test_32b_wrap();
      test_collision();
      test_back_to_back();
      repeat (3) @(negedge clk);
      n_vec++;
      if (beat_q.size() != 0 || rd_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d beats and %0d reads outstanding, required 0 and 0", beat_q.size(), rd_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
